// File: rtl/mem_wb_stage.sv
// mem_wb_stage: back end of the 5-stage pipeline (MEM and WB stages).
//
// Purpose:
//   Registers the execute-stage result (EX/MEM), performs byte-enabled
//   stores and sign/zero-extending loads against a local data memory,
//   selects the write-back value and registers it (MEM/WB) to drive the
//   register-file write port. M-stage state is exported for forwarding.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   validE                   E slot holds a real instruction (0 = bubble)
//   aluResultE, writeDataE   ALU result / byte address, store data
//   rdE, regWriteE           destination register and its write enable
//   memWriteE, mem2regE      store / load markers
//   funct3E                  load/store size and sign code
//   aluResultM, rdM          M-stage result and destination (forwarding)
//   regWriteM                M-stage write enable, qualified by valid
//   regWriteW, rdW, resultW  register-file write port
//   misalignW                W-stage instruction was a misaligned access
//
// The byte-lane logic assumes WORD = 32 (four 8-bit lanes).
module mem_wb_stage #(
  parameter int WORD      = 32,
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            validE,
  input  logic [WORD-1:0] aluResultE,
  input  logic [WORD-1:0] writeDataE,
  input  logic [4:0]      rdE,
  input  logic            regWriteE,
  input  logic            memWriteE,
  input  logic            mem2regE,
  input  logic [2:0]      funct3E,
  output logic [WORD-1:0] aluResultM,
  output logic [4:0]      rdM,
  output logic            regWriteM,
  output logic            regWriteW,
  output logic [4:0]      rdW,
  output logic [WORD-1:0] resultW,
  output logic            misalignW
);

  localparam int NB = WORD / 8;

  // EX/MEM pipeline register
  logic            validM_q;
  logic [WORD-1:0] aluResultM_q;
  logic [WORD-1:0] writeDataM_q;
  logic [4:0]      rdM_q;
  logic            regWriteM_q;
  logic            memWriteM_q;
  logic            mem2regM_q;
  logic [2:0]      funct3M_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      validM_q     <= 1'b0;
      aluResultM_q <= '0;
      writeDataM_q <= '0;
      rdM_q        <= '0;
      regWriteM_q  <= 1'b0;
      memWriteM_q  <= 1'b0;
      mem2regM_q   <= 1'b0;
      funct3M_q    <= '0;
    end else begin
      validM_q     <= validE;
      aluResultM_q <= aluResultE;
      writeDataM_q <= writeDataE;
      rdM_q        <= rdE;
      regWriteM_q  <= regWriteE;
      memWriteM_q  <= memWriteE;
      mem2regM_q   <= mem2regE;
      funct3M_q    <= funct3E;
    end
  end

  // Address decomposition; upper address bits are ignored so addresses wrap.
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        byte_off;
  assign word_idx = aluResultM_q[ADDR_W+1:2];
  assign byte_off = aluResultM_q[1:0];

  // Access size. 101 only denotes a halfword for loads (LHU); as a store
  // code it is undefined and never writes.
  logic is_half, is_word, misalign_m;
  assign is_half    = (funct3M_q == 3'b001) || (funct3M_q == 3'b101 && mem2regM_q);
  assign is_word    = (funct3M_q == 3'b010);
  assign misalign_m = validM_q && (memWriteM_q || mem2regM_q) &&
                      ((is_half && byte_off[0]) || (is_word && byte_off != 2'b00));

  // Store lane enables and lane data: narrow stores replicate their data
  // across lanes so each lane just picks its own byte.
  logic [NB-1:0]   store_be;
  logic [WORD-1:0] store_data;
  logic            store_en;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    always_comb begin
      store_be[gi]           = 1'b0;
      store_data[gi*8 +: 8]  = writeDataM_q[gi*8 +: 8];
      unique case (funct3M_q)
        3'b000: begin
          store_be[gi]          = (byte_off == 2'(gi));
          store_data[gi*8 +: 8] = writeDataM_q[7:0];
        end
        3'b001: begin
          store_be[gi]          = (byte_off[1] == 1'(gi / 2));
          store_data[gi*8 +: 8] = writeDataM_q[(gi % 2)*8 +: 8];
        end
        3'b010:  store_be[gi] = 1'b1;
        default: store_be[gi] = 1'b0;
      endcase
    end
  end

  // A store in M during a reset edge is dropped along with the pipeline.
  assign store_en = validM_q && memWriteM_q && !misalign_m && !reset;

  // Data memory: contents are deliberately not reset. The read is
  // combinational so a load directly behind a store sees the new word.
  logic [WORD-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (store_en && store_be[i]) begin
        mem[word_idx][i*8 +: 8] <= store_data[i*8 +: 8];
      end
    end
  end

  logic [WORD-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [WORD-1:0] load_data;
  logic [WORD-1:0] result_m;

  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{byte_off, 3'b000} +: 8];
  assign rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    if (!misalign_m) begin
      unique case (funct3M_q)
        3'b000:  load_data = {{(WORD-8){rd_byte[7]}}, rd_byte};
        3'b001:  load_data = {{(WORD-16){rd_half[15]}}, rd_half};
        3'b010:  load_data = rd_word;
        3'b100:  load_data = {{(WORD-8){1'b0}}, rd_byte};
        3'b101:  load_data = {{(WORD-16){1'b0}}, rd_half};
        default: load_data = '0;
      endcase
    end
  end

  assign result_m = mem2regM_q ? load_data : aluResultM_q;

  // MEM/WB pipeline register
  logic            validW_q;
  logic            regWriteW_q;
  logic [4:0]      rdW_q;
  logic [WORD-1:0] resultW_q;
  logic            misalignW_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      validW_q    <= 1'b0;
      regWriteW_q <= 1'b0;
      rdW_q       <= '0;
      resultW_q   <= '0;
      misalignW_q <= 1'b0;
    end else begin
      validW_q    <= validM_q;
      regWriteW_q <= regWriteM_q;
      rdW_q       <= rdM_q;
      resultW_q   <= result_m;
      misalignW_q <= misalign_m;
    end
  end

  assign aluResultM = aluResultM_q;
  assign rdM        = rdM_q;
  assign regWriteM  = validM_q & regWriteM_q;
  assign regWriteW  = validW_q & regWriteW_q & (rdW_q != 5'd0);
  assign rdW        = rdW_q;
  assign resultW    = resultW_q;
  assign misalignW  = misalignW_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: table of transactions with
// expected W/M results, driven back to back; expectations are queued on
// issue and compared when the pipeline delivers them, plus hand-written
// reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        validE;
  logic [31:0] aluResultE, writeDataE;
  logic [4:0]  rdE;
  logic        regWriteE, memWriteE, mem2regE;
  logic [2:0]  funct3E;
  logic [31:0] aluResultM;
  logic [4:0]  rdM;
  logic        regWriteM;
  logic        regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        misalignW;

  mem_wb_stage #(.WORD(32), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .validE(validE), .aluResultE(aluResultE),
    .writeDataE(writeDataE), .rdE(rdE), .regWriteE(regWriteE),
    .memWriteE(memWriteE), .mem2regE(mem2regE), .funct3E(funct3E),
    .aluResultM(aluResultM), .rdM(rdM), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .rdW(rdW), .resultW(resultW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic [2:0]  f3;
    logic        e_rw;
    logic [31:0] e_res;
    logic        e_mis;
  } vec_t;

  typedef struct {
    int          due;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
  } wexp_t;

  typedef struct {
    int          due;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
  } mexp_t;

  vec_t  tbl[$];
  wexp_t wq[$];
  mexp_t mq[$];
  int    errors = 0;
  int    checks = 0;

  function automatic vec_t mk(logic v, logic [31:0] alu, logic [31:0] wd, logic [4:0] rd,
                              logic rw, logic mw, logic m2r, logic [2:0] f3,
                              logic e_rw, logic [31:0] e_res, logic e_mis);
    vec_t t;
    t.v = v; t.alu = alu; t.wd = wd; t.rd = rd; t.rw = rw; t.mw = mw; t.m2r = m2r;
    t.f3 = f3; t.e_rw = e_rw; t.e_res = e_res; t.e_mis = e_mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input vec_t t);
    validE = t.v; aluResultE = t.alu; writeDataE = t.wd; rdE = t.rd;
    regWriteE = t.rw; memWriteE = t.mw; mem2regE = t.m2r; funct3E = t.f3;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare every expectation that falls due in the current cycle.
  task automatic service();
    mexp_t m;
    wexp_t w;
    while (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      chk("regWriteM", {31'd0, regWriteM}, {31'd0, m.rw});
      chk("rdM", {27'd0, rdM}, {27'd0, m.rd});
      chk("aluResultM", aluResultM, m.alu);
    end
    while (wq.size() > 0 && wq[0].due <= cyc) begin
      w = wq.pop_front();
      chk("regWriteW", {31'd0, regWriteW}, {31'd0, w.rw});
      chk("rdW", {27'd0, rdW}, {27'd0, w.rd});
      chk("resultW", resultW, w.res);
      chk("misalignW", {31'd0, misalignW}, {31'd0, w.mis});
      $display("txn cyc=%0d rd=%0d regWriteW=%0b resultW=%h misalignW=%0b",
               cyc, rdW, regWriteW, resultW, misalignW);
    end
  endtask

  task automatic issue(input vec_t t);
    wexp_t w;
    mexp_t m;
    drive(t);
    m.due = cyc + 1; m.rw = t.v & t.rw; m.rd = t.rd; m.alu = t.alu;
    w.due = cyc + 2; w.rw = t.e_rw; w.rd = t.rd; w.res = t.e_res; w.mis = t.e_mis;
    mq.push_back(m);
    wq.push_back(w);
    tick();
    service();
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (wq.size() > 0 || mq.size() > 0); k++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick();
      service();
    end
    if (wq.size() > 0 || mq.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations still pending, required 0", wq.size() + mq.size());
      wq.delete();
      mq.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_aluResultM"}, aluResultM, 32'd0);
    chk({tag, "_rdM"}, {27'd0, rdM}, 32'd0);
    chk({tag, "_regWriteM"}, {31'd0, regWriteM}, 32'd0);
    chk({tag, "_regWriteW"}, {31'd0, regWriteW}, 32'd0);
    chk({tag, "_rdW"}, {27'd0, rdW}, 32'd0);
    chk({tag, "_resultW"}, resultW, 32'd0);
    chk({tag, "_misalignW"}, {31'd0, misalignW}, 32'd0);
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  initial begin
    //           v  alu           wd            rd  rw mw m2r f3    e_rw e_res         e_mis
    tbl.push_back(mk(1, 32'h1234,     32'h0,        5,  1, 0, 0, F_W,  1, 32'h00001234, 0));
    tbl.push_back(mk(1, 32'h40,       32'hDEADBEEF, 0,  0, 1, 0, F_W,  0, 32'h00000040, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        1,  1, 0, 1, F_W,  1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(1, 32'h43,       32'h0,        2,  1, 0, 1, F_B,  1, 32'hFFFFFFDE, 0));
    tbl.push_back(mk(1, 32'h43,       32'h0,        3,  1, 0, 1, F_BU, 1, 32'h000000DE, 0));
    tbl.push_back(mk(1, 32'h42,       32'h0,        4,  1, 0, 1, F_H,  1, 32'hFFFFDEAD, 0));
    tbl.push_back(mk(1, 32'h42,       32'h0,        6,  1, 0, 1, F_HU, 1, 32'h0000DEAD, 0));
    tbl.push_back(mk(1, 32'h40,       32'h11223344, 0,  0, 1, 0, F_W,  0, 32'h00000040, 0));
    tbl.push_back(mk(1, 32'h41,       32'hAAAAAA77, 0,  0, 1, 0, F_B,  0, 32'h00000041, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        7,  1, 0, 1, F_W,  1, 32'h11227744, 0));
    tbl.push_back(mk(1, 32'h43,       32'h0000BEEF, 0,  0, 1, 0, F_H,  0, 32'h00000043, 1));
    tbl.push_back(mk(1, 32'h42,       32'h0,        8,  1, 0, 1, F_W,  1, 32'h00000000, 1));
    tbl.push_back(mk(1, 32'h40,       32'h0,        9,  1, 0, 1, F_W,  1, 32'h11227744, 0));
    tbl.push_back(mk(1, 32'h99,       32'h0,        0,  1, 0, 0, F_W,  0, 32'h00000099, 0));
    tbl.push_back(mk(0, 32'h40,       32'h00000BAD, 10, 1, 1, 0, F_W,  0, 32'h00000040, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        11, 1, 0, 1, F_W,  1, 32'h11227744, 0));
    tbl.push_back(mk(1, 32'h1040,     32'hA5A5F00D, 0,  0, 1, 0, F_W,  0, 32'h00001040, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        12, 1, 0, 1, F_W,  1, 32'hA5A5F00D, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        13, 1, 0, 1, F_B,  1, 32'h0000000D, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        14, 1, 0, 1, F_H,  1, 32'hFFFFF00D, 0));
    tbl.push_back(mk(1, 32'h40,       32'h0,        16, 1, 0, 1, 3'b011, 1, 32'h00000000, 0));
    tbl.push_back(mk(1, 32'h80,       32'h55555555, 0,  0, 1, 0, F_W,  0, 32'h00000080, 0));

    // Reset held for two edges with a valid ALU op presented.
    reset = 1'b1;
    drive(tbl[0]);
    tick();
    chk_all_zero("rst1");
    tick();
    chk_all_zero("rst2");
    reset = 1'b0;

    foreach (tbl[i]) issue(tbl[i]);
    drain();

    // Store caught in M by a reset edge must not reach memory.
    drive(mk(1, 32'h80, 32'hCAFEBABE, 0, 0, 1, 0, F_W, 0, 0, 0));
    tick();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    issue(mk(1, 32'h80, 32'h0, 15, 1, 0, 1, F_W, 1, 32'h55555555, 0));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
